// File: rtl/handshake_resp_pkg.sv
// Shared types and timing helper for the req/ack handshake responder.
// The helper is also used by the bench scoreboard to predict ack timing.
package handshake_resp_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  // req_edge is the clock edge at which req is driven high; the responder
  // samples it on the following edge, so ack appears after edge req_edge+1+delay.
  function automatic int ack_edge(input int req_edge, input int delay);
    return req_edge + 1 + delay;
  endfunction

endpackage

// File: rtl/handshake_responder.sv
// Responder side of a req/ack handshake with programmable ack latency,
// pulse or four-phase ack, transaction counting and early-withdrawal flag.
module handshake_responder
  import handshake_resp_pkg::*;
#(
  parameter int DW        = 8,
  parameter bit ACK_PULSE = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             req,
  input  logic [DW-1:0]    ack_delay,
  output logic             ack,
  output logic             busy,
  output logic [CNT_W-1:0] txn_count,
  output logic             err_req_drop
);

  state_t        state, state_nxt;
  logic [DW-1:0] cnt, cnt_nxt;
  logic          err_nxt;
  logic          inc;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    err_nxt   = 1'b0;
    inc       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable && req) begin
          if (ack_delay == '0) begin
            state_nxt = S_ACK;
            inc       = 1'b1;
          end else begin
            cnt_nxt   = ack_delay;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // A withdrawn request wins over counter expiry on the same edge.
        if (!req) begin
          err_nxt   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else if (cnt == DW'(1)) begin
          cnt_nxt   = '0;
          inc       = 1'b1;
          state_nxt = S_ACK;
        end else begin
          cnt_nxt = cnt - DW'(1);
        end
      end
      S_ACK: begin
        if (ACK_PULSE)  state_nxt = S_RELEASE;
        else if (!req)  state_nxt = S_IDLE;
      end
      S_RELEASE: begin
        if (!req) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ack          <= 1'b0;
      busy         <= 1'b0;
      err_req_drop <= 1'b0;
      txn_count    <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      ack          <= (state_nxt == S_ACK);
      busy         <= (state_nxt != S_IDLE);
      err_req_drop <= err_nxt;
      if (inc) txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule
